mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I-cache/D-cache memory arbiter.
// Holds the arbiter state encoding and the default bus widths.
// No logic lives here; every mem_arbiter file imports it.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and shared memory command/response signals.
// Pure wiring, zero latency.
// slave = the arbiter itself, master = the caches plus the memory around it.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              ic_read;
    logic              ic_write;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_wdata;
    logic              ic_ready;
    logic [DATA_W-1:0] ic_rdata;

    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [DATA_W-1:0] dc_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              grant_dc;

    modport slave (
        input  ic_read, ic_write, ic_addr, ic_wdata,
        output ic_ready, ic_rdata,
        input  dc_read, dc_write, dc_addr, dc_wdata,
        output dc_ready, dc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant_dc
    );

    modport master (
        output ic_read, ic_write, ic_addr, ic_wdata,
        input  ic_ready, ic_rdata,
        output dc_read, dc_write, dc_addr, dc_wdata,
        input  dc_ready, dc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant_dc
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between I-cache and D-cache requests.
// Latency: grant registered, command reaches memory one cycle after first seen in IDLE.
// Backpressure: owner waits on mem_ready; a one-cycle RELEASE absorbs the stale request.
// Option: define ARB_ROUND_ROBIN_EN to break ties in favour of the requester not last served.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    mem_arbiter_if.slave bus
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              w_ic_req;
    logic              w_dc_req;
    logic              w_tie_dc;

    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_ic_ready;
    logic [DATA_W-1:0] w_ic_rdata;
    logic              w_dc_ready;
    logic [DATA_W-1:0] w_dc_rdata;

    // A read and a write together still count as one request and pass through as-is.
    assign w_ic_req = bus.ic_read | bus.ic_write;
    assign w_dc_req = bus.dc_read | bus.dc_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dc;

    // Remember who completed last so a tie goes to the other requester.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_last_dc <= 1'b0;
        end else if (bus.mem_ready && (r_state == GRANT_IC)) begin
            r_last_dc <= 1'b0;
        end else if (bus.mem_ready && (r_state == GRANT_DC)) begin
            r_last_dc <= 1'b1;
        end
    end

    assign w_tie_dc = ~r_last_dc;
`else
    // Fixed priority: the D-cache wins every tie.
    assign w_tie_dc = 1'b1;
`endif

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and owner steering of the memory port.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_ic_ready   = 1'b0;
        w_ic_rdata   = '0;
        w_dc_ready   = 1'b0;
        w_dc_rdata   = '0;

        case (r_state)
            IDLE: begin
                if (w_ic_req && w_dc_req) begin
                    w_next_state = w_tie_dc ? GRANT_DC : GRANT_IC;
                end else if (w_dc_req) begin
                    w_next_state = GRANT_DC;
                end else if (w_ic_req) begin
                    w_next_state = GRANT_IC;
                end
            end
            GRANT_IC: begin
                w_mem_read  = bus.ic_read;
                w_mem_write = bus.ic_write;
                w_mem_addr  = bus.ic_addr;
                w_mem_wdata = bus.ic_wdata;
                w_ic_ready  = bus.mem_ready;
                w_ic_rdata  = bus.mem_rdata;
                if (bus.mem_ready) begin
                    w_next_state = RELEASE;
                end else if (!w_ic_req) begin
                    w_next_state = IDLE;
                end
            end
            GRANT_DC: begin
                w_mem_read  = bus.dc_read;
                w_mem_write = bus.dc_write;
                w_mem_addr  = bus.dc_addr;
                w_mem_wdata = bus.dc_wdata;
                w_dc_ready  = bus.mem_ready;
                w_dc_rdata  = bus.mem_rdata;
                if (bus.mem_ready) begin
                    w_next_state = RELEASE;
                end else if (!w_dc_req) begin
                    w_next_state = IDLE;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.ic_ready  = w_ic_ready;
    assign bus.ic_rdata  = w_ic_rdata;
    assign bus.dc_ready  = w_dc_ready;
    assign bus.dc_rdata  = w_dc_rdata;
    assign bus.grant_dc  = (r_state == GRANT_DC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic.
// A transaction-level owner model predicts every output each cycle.
// Build with or without ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    // Model view of who holds the memory port.
    localparam int OWN_NONE = 0;
    localparam int OWN_IC   = 1;
    localparam int OWN_DC   = 2;
    localparam int OWN_COOL = 3;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_owner     = OWN_NONE;
    bit   m_last_dc   = 1'b0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_b(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic quiet_inputs();
        bus.ic_read   = 1'b0;
        bus.ic_write  = 1'b0;
        bus.ic_addr   = '0;
        bus.ic_wdata  = '0;
        bus.dc_read   = 1'b0;
        bus.dc_write  = 1'b0;
        bus.dc_addr   = '0;
        bus.dc_wdata  = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic model_reset();
        m_owner   = OWN_NONE;
        m_last_dc = 1'b0;
    endtask

    // Compare every output against what the current owner implies.
    task automatic model_check(input string tag);
        logic          e_rd, e_wr, e_icr, e_dcr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_icd, e_dcd;
        e_rd = 1'b0; e_wr = 1'b0; e_icr = 1'b0; e_dcr = 1'b0;
        e_addr = '0; e_wd = '0; e_icd = '0; e_dcd = '0;
        if (m_owner == OWN_IC) begin
            e_rd = bus.ic_read;  e_wr = bus.ic_write;
            e_addr = bus.ic_addr; e_wd = bus.ic_wdata;
            e_icr = bus.mem_ready; e_icd = bus.mem_rdata;
        end else if (m_owner == OWN_DC) begin
            e_rd = bus.dc_read;  e_wr = bus.dc_write;
            e_addr = bus.dc_addr; e_wd = bus.dc_wdata;
            e_dcr = bus.mem_ready; e_dcd = bus.mem_rdata;
        end
        chk_b({tag, ".mem_read"},  bus.mem_read,  e_rd);
        chk_b({tag, ".mem_write"}, bus.mem_write, e_wr);
        chk_w({tag, ".mem_addr"},  DW'(bus.mem_addr), DW'(e_addr));
        chk_w({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
        chk_b({tag, ".ic_ready"},  bus.ic_ready,  e_icr);
        chk_w({tag, ".ic_rdata"},  bus.ic_rdata,  e_icd);
        chk_b({tag, ".dc_ready"},  bus.dc_ready,  e_dcr);
        chk_w({tag, ".dc_rdata"},  bus.dc_rdata,  e_dcd);
        chk_b({tag, ".grant_dc"},  bus.grant_dc,  (m_owner == OWN_DC));
    endtask

    // Advance the owner model by one clock using the inputs held over the edge.
    task automatic model_clock();
        bit icq, dcq;
        icq = bus.ic_read | bus.ic_write;
        dcq = bus.dc_read | bus.dc_write;
        if (rst_n) begin
            case (m_owner)
                OWN_NONE: begin
                    if (icq && dcq) begin
`ifdef ARB_ROUND_ROBIN_EN
                        m_owner = m_last_dc ? OWN_IC : OWN_DC;
`else
                        m_owner = OWN_DC;
`endif
                    end else if (icq) begin
                        m_owner = OWN_IC;
                    end else if (dcq) begin
                        m_owner = OWN_DC;
                    end
                end
                OWN_IC: begin
                    if (bus.mem_ready) begin m_owner = OWN_COOL; m_last_dc = 1'b0; end
                    else if (!icq) m_owner = OWN_NONE;
                end
                OWN_DC: begin
                    if (bus.mem_ready) begin m_owner = OWN_COOL; m_last_dc = 1'b1; end
                    else if (!dcq) m_owner = OWN_NONE;
                end
                default: m_owner = OWN_NONE;
            endcase
        end
    endtask

    // Entered at a falling edge with inputs already driven; leaves at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        model_check(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            exp_dc;

        // Reset with live-looking inputs: everything must stay quiet.
        rst_n = 1'b0;
        quiet_inputs();
        bus.ic_read   = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rnd_wide();
        model_reset();
        #12;
        model_check("in_reset");
        chk_b("in_reset_grant", bus.grant_dc, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_inputs();
        cycle("post_reset");

        // I-cache read alone, memory answers on the third granted cycle.
        bus.ic_read = 1'b1;
        bus.ic_addr = AW'(28'h0000010);
        cycle("ic_idle");
        #1;
        chk_b("ic_grant_read", bus.mem_read, 1'b1);
        chk_w("ic_grant_addr", DW'(bus.mem_addr), DW'(28'h0000010));
        cycle("ic_wait1");
        cycle("ic_wait2");
        d = rnd_wide();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = d;
        #1;
        chk_b("ic_ready_pulse", bus.ic_ready, 1'b1);
        chk_w("ic_rdata", bus.ic_rdata, d);
        chk_b("ic_dc_ready_quiet", bus.dc_ready, 1'b0);
        cycle("ic_done");
        #1;
        chk_b("ic_release_read", bus.mem_read, 1'b0);
        chk_b("ic_release_ready", bus.ic_ready, 1'b0);
        cycle("ic_release");
        quiet_inputs();
        cycle("ic_back_idle");

        // Fresh reset, then both caches request together every round.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus.ic_read = 1'b1; bus.ic_addr = AW'(28'h0000100);
            bus.dc_read = 1'b1; bus.dc_addr = AW'(28'h0000200);
            bus.mem_ready = 1'b0;
            cycle("tie_idle");
`ifdef ARB_ROUND_ROBIN_EN
            exp_dc = (r % 2 == 0);
`else
            exp_dc = 1'b1;
`endif
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rnd_wide();
            #1;
            chk_b("tie_winner", bus.grant_dc, exp_dc);
            chk_w("tie_addr", DW'(bus.mem_addr), exp_dc ? DW'(28'h0000200) : DW'(28'h0000100));
            cycle("tie_grant");
            bus.mem_ready = 1'b0;
            #1;
            chk_b("tie_release_read", bus.mem_read, 1'b0);
            cycle("tie_release");
        end
        quiet_inputs();
        cycle("tie_quiet");

        // D-cache write-back followed by a read: two grants, no reissued write.
        bus.dc_write = 1'b1;
        bus.dc_addr  = AW'(28'h0000020);
        bus.dc_wdata = {(DW/8){8'hAA}};
        cycle("wb_idle");
        #1;
        chk_b("wb_write", bus.mem_write, 1'b1);
        chk_w("wb_addr", DW'(bus.mem_addr), DW'(28'h0000020));
        chk_w("wb_wdata", bus.mem_wdata, {(DW/8){8'hAA}});
        bus.mem_ready = 1'b1;
        cycle("wb_grant");
        bus.mem_ready = 1'b0;
        #1;
        chk_b("wb_release_write", bus.mem_write, 1'b0);
        chk_w("wb_release_wdata", bus.mem_wdata, '0);
        cycle("wb_release");
        bus.dc_write = 1'b0;
        bus.dc_read  = 1'b1;
        bus.dc_addr  = AW'(28'h0000040);
        cycle("rd_idle");
        #1;
        chk_b("rd_read", bus.mem_read, 1'b1);
        chk_b("rd_no_write", bus.mem_write, 1'b0);
        chk_w("rd_addr", DW'(bus.mem_addr), DW'(28'h0000040));
        bus.mem_ready = 1'b1;
        cycle("rd_grant");
        quiet_inputs();
        cycle("rd_release");

        // D-cache withdraws before memory answers; waiting I-cache goes next.
        bus.dc_read = 1'b1;
        bus.dc_addr = AW'(28'h0000300);
        cycle("wd_idle");
        bus.ic_read = 1'b1;
        bus.ic_addr = AW'(28'h0000400);
        #1;
        chk_b("wd_grant_dc", bus.grant_dc, 1'b1);
        cycle("wd_grant");
        bus.dc_read = 1'b0;
        cycle("wd_withdraw");
        #1;
        chk_b("wd_idle_grant", bus.grant_dc, 1'b0);
        chk_b("wd_idle_read", bus.mem_read, 1'b0);
        cycle("wd_back_idle");
        #1;
        chk_w("wd_ic_addr", DW'(bus.mem_addr), DW'(28'h0000400));
        bus.mem_ready = 1'b1;
        cycle("wd_ic_grant");
        quiet_inputs();
        cycle("wd_release");

        // Reset dropped between clock edges while the I-cache owns the port.
        bus.ic_read = 1'b1;
        bus.ic_addr = AW'(28'h0000010);
        cycle("ar_idle");
        #2;
        chk_b("ar_before", bus.mem_read, 1'b1);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        model_reset();
        chk_b("ar_mem_read", bus.mem_read, 1'b0);
        chk_w("ar_mem_addr", DW'(bus.mem_addr), '0);
        chk_b("ar_ic_ready", bus.ic_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        cycle("ar_after");
        #1;
        chk_b("ar_regrant", bus.mem_read, 1'b1);
        bus.mem_ready = 1'b1;
        cycle("ar_grant");
        quiet_inputs();
        cycle("ar_release");

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            bus.ic_read   = ($urandom_range(0, 2) == 0);
            bus.ic_write  = ($urandom_range(0, 4) == 0);
            bus.ic_addr   = AW'($urandom);
            bus.ic_wdata  = rnd_wide();
            bus.dc_read   = ($urandom_range(0, 2) == 0);
            bus.dc_write  = ($urandom_range(0, 3) == 0);
            bus.dc_addr   = AW'($urandom);
            bus.dc_wdata  = rnd_wide();
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = rnd_wide();
            cycle("rnd");
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
